// File: rtl/gshare_direction_predictor.sv
// Fetch-stage gshare direction predictor: combines the BTB hit/target with a
// PHT of 2-bit saturating counters indexed by PC XOR global history.
module gshare_direction_predictor #(
   parameter int         HIST_BITS = 5,
   parameter logic [1:0] CNT_INIT  = 2'b01
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [31:0]          current_pc,
   input  logic                 fetch_valid,
   input  logic                 btb_tag_match,
   input  logic [31:0]          btb_target_pc,
   output logic                 predict_taken,
   output logic [31:0]          next_pc,
   output logic [HIST_BITS-1:0] pred_index,
   output logic [HIST_BITS-1:0] pred_ghr,
   input  logic                 update_valid,
   input  logic [HIST_BITS-1:0] update_index,
   input  logic                 update_taken,
   input  logic [HIST_BITS-1:0] update_ghr,
   input  logic                 update_mispredict
);

   localparam int PHT_SIZE = 1 << HIST_BITS;

   logic [1:0]           pht_q [PHT_SIZE];
   logic [HIST_BITS-1:0] ghr_q;
   logic [HIST_BITS-1:0] ghr_d;
   logic [HIST_BITS-1:0] fetch_idx;
   logic [1:0]           upd_cnt;
   logic [1:0]           upd_cnt_d;

   // Prediction reads the registered PHT, so a same-cycle update is not seen.
   always_comb begin
      fetch_idx     = current_pc[HIST_BITS+1:2] ^ ghr_q;
      pred_index    = fetch_idx;
      pred_ghr      = ghr_q;
      predict_taken = btb_tag_match & pht_q[fetch_idx][1];
      next_pc       = predict_taken ? btb_target_pc : current_pc + 32'd4;
   end

   always_comb begin
      upd_cnt   = pht_q[update_index];
      upd_cnt_d = upd_cnt;
      if (update_taken) begin
         if (upd_cnt != 2'b11) upd_cnt_d = upd_cnt + 2'd1;
      end else begin
         if (upd_cnt != 2'b00) upd_cnt_d = upd_cnt - 2'd1;
      end
   end

   // A resolved mispredict repairs history from the EX snapshot and wins over
   // any speculative shift from the fetch path on the same edge.
   always_comb begin
      ghr_d = ghr_q;
      if (update_valid && update_mispredict) begin
         ghr_d = {update_ghr[HIST_BITS-2:0], update_taken};
      end else if (fetch_valid && btb_tag_match) begin
         ghr_d = {ghr_q[HIST_BITS-2:0], predict_taken};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ghr_q <= '0;
      end else begin
         ghr_q <= ghr_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < PHT_SIZE; i++) begin
            pht_q[i] <= CNT_INIT;
         end
      end else if (update_valid) begin
         pht_q[update_index] <= upd_cnt_d;
      end
   end

endmodule

// File: tb/tb_gshare_direction_predictor.sv
// Bench for gshare_direction_predictor: directed vector table, a mid-cycle
// reset sequence, then random traffic checked against a reference model.
module tb_gshare_direction_predictor;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] current_pc;
   logic        fetch_valid;
   logic        btb_tag_match;
   logic [31:0] btb_target_pc;
   logic        predict_taken;
   logic [31:0] next_pc;
   logic [4:0]  pred_index;
   logic [4:0]  pred_ghr;
   logic        update_valid;
   logic [4:0]  update_index;
   logic        update_taken;
   logic [4:0]  update_ghr;
   logic        update_mispredict;

   gshare_direction_predictor #(.HIST_BITS(5), .CNT_INIT(2'b01)) dut (
      .clk(clk), .reset(reset),
      .current_pc(current_pc), .fetch_valid(fetch_valid),
      .btb_tag_match(btb_tag_match), .btb_target_pc(btb_target_pc),
      .predict_taken(predict_taken), .next_pc(next_pc),
      .pred_index(pred_index), .pred_ghr(pred_ghr),
      .update_valid(update_valid), .update_index(update_index),
      .update_taken(update_taken), .update_ghr(update_ghr),
      .update_mispredict(update_mispredict)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic        fv;
      logic        hit;
      logic [31:0] tgt;
      logic        uv;
      logic [4:0]  uidx;
      logic        ut;
      logic [4:0]  ughr;
      logic        umis;
   } vin_t;

   typedef struct {
      logic        taken;
      logic [31:0] npc;
      logic [4:0]  idx;
      logic [4:0]  ghr;
   } vexp_t;

   typedef struct {
      vin_t  i;
      vexp_t e;
   } row_t;

   row_t  rows[$];
   vexp_t exp_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;

   logic [1:0] m_pht [32];
   logic [4:0] m_ghr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vin_t mkin(input logic [31:0] pc, input logic fv, input logic hit,
                                 input logic [31:0] tgt, input logic uv, input logic [4:0] uidx,
                                 input logic ut, input logic [4:0] ughr, input logic umis);
      vin_t v;
      v.pc = pc; v.fv = fv; v.hit = hit; v.tgt = tgt; v.uv = uv;
      v.uidx = uidx; v.ut = ut; v.ughr = ughr; v.umis = umis;
      return v;
   endfunction

   function automatic vexp_t mkexp(input logic t, input logic [31:0] npc,
                                   input logic [4:0] idx, input logic [4:0] ghr);
      vexp_t e;
      e.taken = t; e.npc = npc; e.idx = idx; e.ghr = ghr;
      return e;
   endfunction

   task automatic add_row(input vin_t v, input vexp_t e);
      row_t r;
      r.i = v; r.e = e;
      rows.push_back(r);
   endtask

   function automatic vexp_t model_pred(input vin_t v);
      vexp_t e;
      logic [4:0] idx;
      idx     = v.pc[6:2] ^ m_ghr;
      e.idx   = idx;
      e.ghr   = m_ghr;
      e.taken = v.hit & m_pht[idx][1];
      e.npc   = e.taken ? v.tgt : v.pc + 32'd4;
      return e;
   endfunction

   task automatic model_edge(input vin_t v);
      vexp_t e;
      e = model_pred(v);
      if (v.uv) begin
         if (v.ut && m_pht[v.uidx] != 2'b11) m_pht[v.uidx] = m_pht[v.uidx] + 2'd1;
         else if (!v.ut && m_pht[v.uidx] != 2'b00) m_pht[v.uidx] = m_pht[v.uidx] - 2'd1;
      end
      if (v.uv && v.umis) m_ghr = {v.ughr[3:0], v.ut};
      else if (v.fv && v.hit) m_ghr = {m_ghr[3:0], e.taken};
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_pht[i] = 2'b01;
      m_ghr = '0;
   endtask

   task automatic drive(input vin_t v);
      current_pc        = v.pc;
      fetch_valid       = v.fv;
      btb_tag_match     = v.hit;
      btb_target_pc     = v.tgt;
      update_valid      = v.uv;
      update_index      = v.uidx;
      update_taken      = v.ut;
      update_ghr        = v.ughr;
      update_mispredict = v.umis;
   endtask

   // Drive one cycle, push its expectation, compare at the negedge, cross the edge.
   task automatic step(input string tag, input vin_t v, input vexp_t e);
      vexp_t x;
      drive(v);
      exp_q.push_back(e);
      @(negedge clk);
      if (exp_q.size() == 0) begin
         chk({tag, " scoreboard_empty"}, 32'd0, 32'd1);
      end else begin
         x = exp_q.pop_front();
         chk({tag, " predict_taken"}, {31'd0, predict_taken}, {31'd0, x.taken});
         chk({tag, " next_pc"}, next_pc, x.npc);
         chk({tag, " pred_index"}, {27'd0, pred_index}, {27'd0, x.idx});
         chk({tag, " pred_ghr"}, {27'd0, pred_ghr}, {27'd0, x.ghr});
      end
      @(posedge clk);
      model_edge(v);
      #1;
   endtask

   task automatic do_reset();
      drive(mkin(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0));
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      vin_t  v;
      vexp_t e;
      logic [31:0] r;

      // counter warm-up and saturation at idx 0
      add_row(mkin(32'h100, 0, 1, 32'h200, 0, 5'd0, 0, 5'd0, 0), mkexp(0, 32'h104, 5'd0, 5'd0));
      add_row(mkin(32'h100, 0, 1, 32'h200, 1, 5'd0, 1, 5'd0, 0), mkexp(0, 32'h104, 5'd0, 5'd0));
      add_row(mkin(32'h100, 0, 1, 32'h200, 1, 5'd0, 1, 5'd0, 0), mkexp(1, 32'h200, 5'd0, 5'd0));
      add_row(mkin(32'h100, 0, 1, 32'h200, 1, 5'd0, 1, 5'd0, 0), mkexp(1, 32'h200, 5'd0, 5'd0));
      add_row(mkin(32'h100, 0, 1, 32'h200, 0, 5'd0, 0, 5'd0, 0), mkexp(1, 32'h200, 5'd0, 5'd0));
      add_row(mkin(32'h100, 0, 1, 32'h200, 1, 5'd0, 0, 5'd0, 0), mkexp(1, 32'h200, 5'd0, 5'd0));
      add_row(mkin(32'h100, 0, 1, 32'h200, 0, 5'd0, 0, 5'd0, 0), mkexp(1, 32'h200, 5'd0, 5'd0));
      // floor saturation at idx 3, then climb back to weakly taken
      add_row(mkin(32'h00C, 0, 1, 32'h300, 1, 5'd3, 0, 5'd0, 0), mkexp(0, 32'h010, 5'd3, 5'd0));
      add_row(mkin(32'h00C, 0, 1, 32'h300, 1, 5'd3, 0, 5'd0, 0), mkexp(0, 32'h010, 5'd3, 5'd0));
      add_row(mkin(32'h00C, 0, 1, 32'h300, 1, 5'd3, 0, 5'd0, 0), mkexp(0, 32'h010, 5'd3, 5'd0));
      add_row(mkin(32'h00C, 0, 1, 32'h300, 1, 5'd3, 1, 5'd0, 0), mkexp(0, 32'h010, 5'd3, 5'd0));
      add_row(mkin(32'h00C, 0, 1, 32'h300, 1, 5'd3, 1, 5'd0, 0), mkexp(0, 32'h010, 5'd3, 5'd0));
      add_row(mkin(32'h00C, 0, 1, 32'h300, 0, 5'd0, 0, 5'd0, 0), mkexp(1, 32'h300, 5'd3, 5'd0));
      add_row(mkin(32'h00C, 0, 0, 32'h300, 0, 5'd0, 0, 5'd0, 0), mkexp(0, 32'h010, 5'd3, 5'd0));
      // speculative GHR shifts NT then T, then stalls and a miss hold it
      add_row(mkin(32'h004, 1, 1, 32'h400, 0, 5'd0, 0, 5'd0, 0), mkexp(0, 32'h008, 5'd1, 5'd0));
      add_row(mkin(32'h00C, 1, 1, 32'h300, 0, 5'd0, 0, 5'd0, 0), mkexp(1, 32'h300, 5'd3, 5'd0));
      add_row(mkin(32'h00C, 0, 1, 32'h300, 0, 5'd0, 0, 5'd0, 0), mkexp(0, 32'h010, 5'd2, 5'd1));
      add_row(mkin(32'h00C, 0, 1, 32'h300, 0, 5'd0, 0, 5'd0, 0), mkexp(0, 32'h010, 5'd2, 5'd1));
      add_row(mkin(32'h00C, 0, 1, 32'h300, 0, 5'd0, 0, 5'd0, 0), mkexp(0, 32'h010, 5'd2, 5'd1));
      add_row(mkin(32'h00C, 1, 0, 32'h300, 0, 5'd0, 0, 5'd0, 0), mkexp(0, 32'h010, 5'd2, 5'd1));
      // mispredict repair beats same-edge fetch shift; PHT[7] trained too
      add_row(mkin(32'h00C, 1, 1, 32'h300, 1, 5'd7, 1, 5'b10110, 1), mkexp(0, 32'h010, 5'd2, 5'd1));
      add_row(mkin(32'h028, 0, 1, 32'h500, 0, 5'd0, 0, 5'd0, 0), mkexp(1, 32'h500, 5'd7, 5'b01101));
      // mispredict flag without update_valid is ignored
      add_row(mkin(32'h028, 0, 1, 32'h500, 0, 5'd9, 0, 5'd0, 1), mkexp(1, 32'h500, 5'd7, 5'b01101));
      add_row(mkin(32'h028, 0, 1, 32'h500, 0, 5'd0, 0, 5'd0, 0), mkexp(1, 32'h500, 5'd7, 5'b01101));

      do_reset();
      for (int k = 0; k < rows.size(); k++) begin
         step($sformatf("row%0d", k), rows[k].i, rows[k].e);
      end

      // reset asserted between edges: effect must be immediate
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst ghr", {27'd0, pred_ghr}, 32'd0);
      chk("async_rst index", {27'd0, pred_index}, 32'd10);
      chk("async_rst taken", {31'd0, predict_taken}, 32'd0);
      drive(mkin(32'h100, 1, 1, 32'h200, 1, 5'd0, 1, 5'b11111, 1));
      #1;
      chk("rst_held taken", {31'd0, predict_taken}, 32'd0);
      chk("rst_held next_pc", next_pc, 32'h104);
      @(posedge clk);
      #1;
      chk("rst_held ghr_after_edge", {27'd0, pred_ghr}, 32'd0);
      reset = 1'b0;
      drive(mkin(32'h100, 0, 1, 32'h200, 0, 5'd0, 0, 5'd0, 0));
      #1;
      chk("post_rst taken", {31'd0, predict_taken}, 32'd0);
      chk("post_rst next_pc", next_pc, 32'h104);
      drive(mkin(32'hFFFF_FFFC, 0, 0, 32'h200, 0, 5'd0, 0, 5'd0, 0));
      #1;
      chk("wrap next_pc", next_pc, 32'h0);
      chk("wrap index", {27'd0, pred_index}, 32'd31);
      @(posedge clk);
      #1;
      model_reset();

      // random traffic against the reference model
      for (int k = 0; k < 300; k++) begin
         r = $urandom;
         r[1:0] = 2'b00;
         if ($urandom_range(0, 15) == 0) r = 32'hFFFF_FFFC;
         v = mkin(r, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                  $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 3) == 0));
         e = model_pred(v);
         step($sformatf("rnd%0d", k), v, e);
      end

      if (exp_q.size() != 0) chk("scoreboard_leftover", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1);
   end

endmodule
